lcd_write_sched: RTL and testbench
==================================

Name: lcd_write_sched

Overview:
- Sequences all writes to the character LCD (HD44780-style, 8-bit bus, write-only).
- After reset it waits out the power-up delay and issues the fixed init sequence. It then serves a valid/ready request port, one command or data byte per request.
- It generates setup, enable-pulse, hold and execution-wait timing from cycle-count parameters.
- It sits between the display-content logic (text/scroll generators) and the LCD pins, and replaces free-running enable toggling.

Parameters:
- T_PWR, 1500000: power-up wait before first init write, in clk cycles (15 ms at 100 MHz).
- T_SU, 4: cycles rs/data are stable before lcd_e rises; also used as hold after lcd_e falls.
- T_EH, 50: lcd_e high width, in cycles.
- T_WAIT, 4000: execution wait after a normal write (40 us).
- T_CLR, 164000: execution wait after clear/home commands (1.64 ms).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: requester has a byte to write.
- req_rs, in, 1: 0 = command, 1 = data.
- req_data, in, 8: byte to write.
- req_ready, out, 1: block accepts the request this cycle.
- busy, out, 1: high whenever state is not IDLE.
- init_done, out, 1: init sequence complete; stays high until reset.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write; tied 0.
- lcd_e, out, 1: LCD enable.
- data, out, 8: LCD data bus.

Behaviour:
- Reset values (all registered outputs): lcd_e=0, lcd_rs=0, lcd_rw=0, data=0x00, req_ready=0, init_done=0. The state is PWRUP, so busy=1. The wait counter and init index are cleared.
- States: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
- PWRUP: count T_PWR cycles, then go to INIT_LOAD.
- INIT_LOAD: load the init ROM entry at the current index (rs=0), then go to SETUP. The ROM holds 0x38, 0x0C, 0x06, 0x01, in that order.
- IDLE: req_ready=1 only when init_done=1. On req_valid&&req_ready, latch req_rs and req_data and go to SETUP. req_ready drops in the cycle after the accepting edge.
- SETUP: drive lcd_rs and data from the latched values, lcd_e=0, for T_SU cycles.
- PULSE: lcd_e=1 for exactly T_EH cycles. rs and data are held.
- HOLD: lcd_e=0, rs and data held, for T_SU cycles.
- WAIT: count the execution wait, with lcd_e=0.
  - The long wait T_CLR applies when rs=0 and data is 0x01, 0x02 or 0x03 (data[7:2]==0 && data!=0). Every other byte uses T_WAIT.
  - On expiry during init: increment the index and go to INIT_LOAD. After the 4th entry, set init_done=1 and go to IDLE.
  - On expiry otherwise: go to IDLE.
- Timing: a normal write occupies 2*T_SU+T_EH+T_WAIT cycles from the accepting edge to req_ready high again; a clear/home write uses T_CLR in place of T_WAIT.
- Requests presented before init_done are neither accepted nor dropped. The requester holds them; the first is accepted in the first IDLE cycle.
- Back-to-back requests: at most one accept per transaction. Order is preserved. There are no gaps beyond the mandated timing.
- Reset mid-operation (any state): on the next edge lcd_e=0 and init_done=0, and the full power-up and init sequence is redone. Partial writes are abandoned.
- Counters: one shared down-counter, width $clog2(max(T_PWR, T_CLR))+1, loaded on state entry. A state exits when the counter reaches 0. Zero-valued parameters are illegal and are asserted against in simulation.
- lcd_rw is constant 0. No busy-flag readback.

Decomposition:
- Package lcd_pkg holds:
  - command constants: LCD_FUNC_8B_2L=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY_INC=0x06, LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_DDRAM_LINE2=0xC0;
  - INIT_LEN=4 and the init ROM contents;
  - the state enum.
- Sub-module lcd_init_rom: combinational index-to-byte lookup. All else is flat.

Test Plan:
Bench parameters: T_PWR=20, T_SU=2, T_EH=5, T_WAIT=10, T_CLR=30.
- Reset release -> lcd_e stays 0 for 20 cycles. Then four writes of 0x38, 0x0C, 0x06, 0x01 with rs=0, each with e high exactly 5 cycles and data stable 2 cycles before and after. The 0x01 write is followed by a 30-cycle wait. init_done rises afterwards.
- After init, req 0x41 with rs=1 -> lcd_rs=1 and data=0x41 two cycles before e rises; e high 5 cycles; req_ready high again 19 cycles after the accepting edge.
- Command 0x01 with rs=0 -> req_ready returns 39 cycles after accept. 0xC0 with rs=0 -> 19 cycles.
- req_valid held high with 0x41, 0x4D, 0x52 queued from before init_done -> none accepted before init_done. The three bytes then appear on the bus in order, each accepted exactly once.
- rst pulsed for 1 cycle while lcd_e=1 in PULSE -> next edge lcd_e=0, init_done=0, req_ready=0. The power-up wait and the full init sequence then repeat.
- req_valid toggled while busy -> no acceptance and no bus change until the IDLE cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, init ROM contents and state encoding for
//               the HD44780-style character LCD write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8B_2L  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON     = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC   = 8'h06;
    localparam logic [7:0] LCD_CLEAR       = 8'h01;
    localparam logic [7:0] LCD_HOME        = 8'h02;
    localparam logic [7:0] LCD_DDRAM_LINE2 = 8'hC0;

    localparam int INIT_LEN   = 4;
    localparam int INIT_IDX_W = $clog2(INIT_LEN);

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        LCD_FUNC_8B_2L,
        LCD_DISP_ON,
        LCD_ENTRY_INC,
        LCD_CLEAR
    };

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_PULSE     = 3'd4,
        ST_HOLD      = 3'd5,
        ST_WAIT      = 3'd6
    } lcd_state_e;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_rom
// Description : Combinational lookup of the LCD power-up init command bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] i_idx,
    output logic [7:0]            o_byte
);

    assign o_byte = INIT_ROM[i_idx];

endmodule
`default_nettype wire

// File: rtl/lcd_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_sched
// Description : Power-up init and timed write sequencing for an 8-bit,
//               write-only HD44780-style character LCD.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_sched
    import lcd_pkg::*;
#(
    parameter int T_PWR  = 1500000,
    parameter int T_SU   = 4,
    parameter int T_EH   = 50,
    parameter int T_WAIT = 4000,
    parameter int T_CLR  = 164000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] data
);

    localparam int C_MAX_T = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int C_CNT_W = $clog2(C_MAX_T) + 1;

    localparam logic [C_CNT_W-1:0] C_LD_PWR  = C_CNT_W'(T_PWR - 1);
    localparam logic [C_CNT_W-1:0] C_LD_SU   = C_CNT_W'(T_SU - 1);
    localparam logic [C_CNT_W-1:0] C_LD_EH   = C_CNT_W'(T_EH - 1);
    localparam logic [C_CNT_W-1:0] C_LD_WAIT = C_CNT_W'(T_WAIT - 1);
    localparam logic [C_CNT_W-1:0] C_LD_CLR  = C_CNT_W'(T_CLR - 1);
    localparam logic [INIT_IDX_W-1:0] C_LAST_IDX = INIT_IDX_W'(INIT_LEN - 1);

    lcd_state_e              r_state;
    lcd_state_e              w_state_nxt;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_CNT_W-1:0]      w_cnt_nxt;
    logic [INIT_IDX_W-1:0]   r_idx;
    logic [INIT_IDX_W-1:0]   w_idx_nxt;
    logic                    r_init_done;
    logic                    w_init_done_nxt;
    logic                    r_req_ready;
    logic                    r_lcd_e;
    logic                    r_lcd_rs;
    logic                    w_rs_nxt;
    logic [7:0]              r_data;
    logic [7:0]              w_data_nxt;
    logic [7:0]              w_rom_byte;
    logic                    w_cnt_zero;
    logic                    w_accept;

    lcd_init_rom u_init_rom (
        .i_idx  (r_idx),
        .o_byte (w_rom_byte)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = r_req_ready && req_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - C_CNT_W'(1);
        w_idx_nxt       = r_idx;
        w_init_done_nxt = r_init_done;
        w_rs_nxt        = r_lcd_rs;
        w_data_nxt      = r_data;

        case (r_state)
            ST_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_INIT_LOAD;
                end
            end
            ST_INIT_LOAD: begin
                w_rs_nxt    = 1'b0;
                w_data_nxt  = w_rom_byte;
                w_cnt_nxt   = C_LD_SU;
                w_state_nxt = ST_SETUP;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_rs_nxt    = req_rs;
                    w_data_nxt  = req_data;
                    w_cnt_nxt   = C_LD_SU;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = C_LD_EH;
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = C_LD_SU;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = is_long_cmd(r_lcd_rs, r_data) ? C_LD_CLR : C_LD_WAIT;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    if (r_init_done) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_idx == C_LAST_IDX) begin
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + INIT_IDX_W'(1);
                        w_state_nxt = ST_INIT_LOAD;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = C_LD_PWR;
                w_state_nxt = ST_PWRUP;
            end
        endcase
    end

    // Reset is the entry into PWRUP, so the counter is loaded for it here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= C_LD_PWR;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_req_ready <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE) && w_init_done_nxt;
            r_lcd_e     <= (w_state_nxt == ST_PULSE);
            r_lcd_rs    <= w_rs_nxt;
            r_data      <= w_data_nxt;
        end
    end

    a_timing_nonzero: assert property (@(posedge clk)
        (T_PWR > 0) && (T_SU > 0) && (T_EH > 0) && (T_WAIT > 0) && (T_CLR > 0));

    assign req_ready = r_req_ready;
    assign busy      = (r_state != ST_IDLE);
    assign init_done = r_init_done;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_lcd_e;
    assign data      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_write_sched
// Description : Self-checking bench for lcd_write_sched with a bus monitor
//               feeding a scoreboard of expected LCD writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_write_sched;

    localparam int T_PWR  = 20;
    localparam int T_SU   = 2;
    localparam int T_EH   = 5;
    localparam int T_WAIT = 10;
    localparam int T_CLR  = 30;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] data;

    lcd_write_sched #(
        .T_PWR  (T_PWR),
        .T_SU   (T_SU),
        .T_EH   (T_EH),
        .T_WAIT (T_WAIT),
        .T_CLR  (T_CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .busy      (busy),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .data      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Bus monitor: setup/hold stability, enable width, then scoreboard pop.
    logic [8:0] h1, h2, cur, bus;
    bit         prev_e, in_hold;
    int         e_hi;
    always @(negedge clk) begin
        bus = {lcd_rs, data};
        if (rst) begin
            prev_e  = 1'b0;
            in_hold = 1'b0;
            e_hi    = 0;
            h1      = '0;
            h2      = '0;
        end else begin
            if (lcd_e && !prev_e) begin
                chk("setup_stable", {14'd0, h2, h1}, {14'd0, bus, bus});
                cur  = bus;
                e_hi = 1;
            end else if (lcd_e) begin
                e_hi++;
                chk("pulse_stable", {23'd0, bus}, {23'd0, cur});
            end else if (prev_e) begin
                chk("e_width", e_hi, T_EH);
                chk("hold1", {23'd0, bus}, {23'd0, cur});
                in_hold = 1'b1;
            end else if (in_hold) begin
                chk("hold2", {23'd0, bus}, {23'd0, cur});
                in_hold = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", {23'd0, bus}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_write", {23'd0, bus}, {23'd0, exp_q.pop_front()});
                end
            end
            h2     = h1;
            h1     = bus;
            prev_e = lcd_e;
        end
    end

    // Called just after the last reset edge; counts edges from it.
    task automatic run_init();
        int n = 0;
        int first_e = -1;
        int done_at = -1;
        while (done_at < 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (lcd_e && first_e < 0) first_e = n;
            if (init_done && done_at < 0) done_at = n;
        end
        chk("init_first_e", first_e, 23);
        chk("init_done_at", done_at, 120);
        chk("init_ready", {31'd0, req_ready}, 1);
        chk("init_busy", {31'd0, busy}, 0);
        chk("init_sb_empty", exp_q.size(), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 1);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input int lat, input bit toggle);
        int n = 0;
        bit changed = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        exp_q.push_back({rs, d});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_drop", {31'd0, req_ready}, 0);
        chk("busy_after_acc", {31'd0, busy}, 1);
        while (!req_ready && n < 500) begin
            if (toggle) begin
                req_valid = ~req_valid;
                req_rs    = 1'b0;
                req_data  = 8'h5A;
            end
            @(posedge clk); #1;
            n++;
            if ({lcd_rs, data} !== {rs, d}) changed = 1'b1;
        end
        req_valid = 1'b0;
        chk($sformatf("latency_%0d_%02h", rs, d), n, lat);
        if (toggle) chk("toggle_bus_hold", {31'd0, changed}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] qb[3];
        int acc[3];
        int k, n, done_at;
        bit will;

        vecs[0].rs = 1'b1; vecs[0].d = 8'h41; vecs[0].lat = 19;
        vecs[1].rs = 1'b0; vecs[1].d = 8'h01; vecs[1].lat = 39;
        vecs[2].rs = 1'b0; vecs[2].d = 8'hC0; vecs[2].lat = 19;
        vecs[3].rs = 1'b0; vecs[3].d = 8'h02; vecs[3].lat = 39;
        vecs[4].rs = 1'b0; vecs[4].d = 8'h03; vecs[4].lat = 39;
        vecs[5].rs = 1'b0; vecs[5].d = 8'h04; vecs[5].lat = 19;
        vecs[6].rs = 1'b1; vecs[6].d = 8'h01; vecs[6].lat = 19;
        vecs[7].rs = 1'b0; vecs[7].d = 8'h00; vecs[7].lat = 19;

        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_e", {31'd0, lcd_e}, 0);
        chk("rst_lcd_rs", {31'd0, lcd_rs}, 0);
        chk("rst_lcd_rw", {31'd0, lcd_rw}, 0);
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_ready", {31'd0, req_ready}, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        push_init();
        run_init();

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].rs, vecs[i].d, vecs[i].lat, 1'b0);
        end

        // Requests toggling while busy must not be taken until IDLE.
        do_write(1'b1, 8'h41, 19, 1'b1);
        do_write(1'b0, 8'h5A, 19, 1'b0);
        chk("idle_rw", {31'd0, lcd_rw}, 0);

        // Reset in the middle of an enable pulse.
        wait_ready();
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h4D;
        exp_q.push_back({1'b1, 8'h4D});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_saw_e", {31'd0, lcd_e}, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_lcd_e", {31'd0, lcd_e}, 0);
        chk("midrst_init_done", {31'd0, init_done}, 0);
        chk("midrst_ready", {31'd0, req_ready}, 0);
        chk("midrst_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        push_init();
        run_init();

        // Requests held from before init_done: accepted in order, once each.
        qb[0] = 8'h41; qb[1] = 8'h4D; qb[2] = 8'h52;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_init();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, qb[i]});
        req_valid = 1'b1; req_rs = 1'b1; req_data = qb[0];
        k = 0; n = 0; done_at = -1;
        for (int i = 0; i < 3; i++) acc[i] = -1;
        while (k < 3 && n < 600) begin
            will = req_valid && req_ready;
            @(posedge clk); #1;
            n++;
            if (init_done && done_at < 0) done_at = n;
            if (will) begin
                acc[k] = n;
                k++;
                if (k < 3) req_data = qb[k];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("q_init_done_at", done_at, 120);
        chk("q_accepts", k, 3);
        chk("q_acc0", acc[0], 121);
        chk("q_acc1", acc[1], 141);
        chk("q_acc2", acc[2], 161);
        wait_ready();
        chk("q_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
